clock_divider_controller: RTL

//   Runtime-configurable clock-division controller for the LED-blink path.
//   - Generates clk_out with half-period = cur_rate cycles of clk_in.
//   - Accepts new division rates over a valid/ready handshake.
//   - Starts and stops division glitch-free under an enable input.
//   - Commits rate changes only at clk_out high->low transitions, so every low+high pair is symmetric.
//

---
 rtl/clock_divider_controller_if.sv | 34 +++
 rtl/clock_divider_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/clock_divider_controller_if.sv
// ----------------------------------------------------------------------------
// clock_divider_controller_if
//   Rate-request handshake bundle for the LED-blink clock divider.
//
//   cfg_valid   requester -> divider   rate request valid
//   cfg_rate    requester -> divider   requested half-period in clk_in cycles
//   cfg_ready   divider -> requester   divider can accept a request
//   cfg_err     divider -> requester   one-cycle pulse, zero rate rejected
//
//   master : the requester side (testbench / register block)
//   slave  : the divider side
// ----------------------------------------------------------------------------
interface clock_divider_controller_if #(
    parameter int RATE_W = 8
);
    logic              cfg_valid;
    logic [RATE_W-1:0] cfg_rate;
    logic              cfg_ready;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_rate,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_rate,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_divider_controller.sv
// ----------------------------------------------------------------------------
// clock_divider_controller
//   Runtime-configurable clock divider for the LED-blink path. clk_out has a
//   half-period of cur_rate clk_in cycles. New rates arrive over a valid/ready
//   handshake and are only put in force on a clk_out high->low toggle, so
//   every low+high pair is symmetric. Start/stop under en is glitch-free:
//   clk_out is always a flop output and is forced low while stopped.
//
//   Ports
//   clk_in     in   system clock
//   rst        in   asynchronous reset, active-high
//   en         in   1 = run divider, 0 = stop (clk_out held 0)
//   cfg        if   rate-request handshake (slave modport)
//   clk_out    out  divided clock (registered)
//   edge_tick  out  one-cycle pulse registered with each clk_out toggle
//   cur_rate   out  rate currently in force (never 0)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   STOPPED | divider idle, clk_out low; accepted rates take effect at once
//   RUN     | dividing at cur_rate, no rate waiting
//   PEND    | dividing at cur_rate, pend_rate waits for next falling toggle
// ----------------------------------------------------------------------------
module clock_divider_controller #(
    parameter int RATE_W       = 8,
    parameter int DEFAULT_RATE = 3
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic                        en,
    clock_divider_controller_if.slave   cfg,
    output logic                        clk_out,
    output logic                        edge_tick,
    output logic [RATE_W-1:0]           cur_rate
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_PEND    = 2'd2
    } state_t;

    localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(DEFAULT_RATE);
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [RATE_W-1:0] cnt;
    logic [RATE_W-1:0] cnt_nxt;
    logic [RATE_W-1:0] pend_rate;
    logic [RATE_W-1:0] pend_nxt;
    logic [RATE_W-1:0] cur_nxt;
    logic              clk_nxt;
    logic              tick_nxt;
    logic              err_nxt;
    logic              cfg_err_q;

    logic              accept;
    logic              accept_ok;
    logic              terminal;

    // Only one request can be outstanding; the slot is full exactly in PEND.
    assign cfg.cfg_ready = (state != ST_PEND);
    assign cfg.cfg_err   = cfg_err_q;

    assign accept    = cfg.cfg_valid & cfg.cfg_ready;
    assign accept_ok = accept & (cfg.cfg_rate != '0);
    // cur_rate >= 1 always, so the subtraction cannot underflow.
    assign terminal  = (cnt == (cur_rate - RATE_ONE));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= ST_STOPPED;
            cnt       <= '0;
            clk_out   <= 1'b0;
            edge_tick <= 1'b0;
            cfg_err_q <= 1'b0;
            cur_rate  <= RATE_RST;
            pend_rate <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clk_out   <= clk_nxt;
            edge_tick <= tick_nxt;
            cfg_err_q <= err_nxt;
            cur_rate  <= cur_nxt;
            pend_rate <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clk_nxt   = clk_out;
        tick_nxt  = 1'b0;
        err_nxt   = accept & (cfg.cfg_rate == '0);
        cur_nxt   = cur_rate;
        pend_nxt  = pend_rate;

        case (state)
            ST_STOPPED: begin
                if (accept_ok) begin
                    cur_nxt = cfg.cfg_rate;
                end
                if (en) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end

            ST_RUN, ST_PEND: begin
                if (!en) begin
                    // Stopping wins over toggle and commit; whatever rate is
                    // waiting becomes the rate for the next start.
                    state_nxt = ST_STOPPED;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                    if (state == ST_PEND) begin
                        cur_nxt = pend_rate;
                    end else if (accept_ok) begin
                        cur_nxt = cfg.cfg_rate;
                    end
                end else begin
                    if (terminal) begin
                        cnt_nxt  = '0;
                        clk_nxt  = ~clk_out;
                        tick_nxt = 1'b1;
                        // Commit only on the falling toggle so the new rate
                        // governs the low phase that starts here.
                        if ((state == ST_PEND) && clk_out) begin
                            cur_nxt   = pend_rate;
                            state_nxt = ST_RUN;
                        end
                    end else begin
                        cnt_nxt = cnt + RATE_ONE;
                    end
                    // accept_ok is only possible in RUN (ready low in PEND),
                    // so a request taken on a falling toggle waits for the
                    // next falling toggle.
                    if (accept_ok) begin
                        pend_nxt  = cfg.cfg_rate;
                        state_nxt = ST_PEND;
                    end
                end
            end

            default: begin
                state_nxt = ST_STOPPED;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    a_rate_nonzero : assert property (@(posedge clk_in) disable iff (rst) cur_rate != '0);

endmodule
